alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Decode-side driver of the integer ALU: accepts raw RV32I instruction words, decodes opcode/funct3/funct7 to the 4-bit ALU op codes in constants.v.
//  Holds op, operand selects and immediate in a valid/ready pipeline register facing the ALU stage.
//  Samples the ALU's zero/result-LSB back to resolve branches one cycle after issue. Sits between fetch and execute.
// PARAMETERS
//  XLEN     32   datapath width of imm_out and pc; must be 32 (RV32I)
//  CNT_W    16   width of statistics counters (only with ALU_ISSUE_STATS_EN)
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  in_valid     in   1      instr_in/pc_in valid
//  in_ready     out  1      stage can accept
//  instr_in     in   32     instruction word
//  pc_in        in   XLEN   PC of instr_in
//  flush        in   1      kill held and incoming instruction
//  out_valid    out  1      decoded op valid toward ALU
//  out_ready    in   1      ALU stage accepts
//  alu_op       out  4      ALU op code (constants.v encoding)
//  src_a_pc     out  1      1: operand A = pc_out (AUIPC, JAL/JALR link)
//  src_b_imm    out  1      1: operand B = imm_out
//  imm_out      out  XLEN   sign-extended immediate (I/S/B/U/J per format)
//  pc_out       out  XLEN   PC of held instruction
//  illegal      out  1      held instruction not decodable (qualified by out_valid)
//  alu_zero     in   1      ALU zero flag, same cycle as alu_op
//  alu_lsb      in   1      ALU result bit 0, same cycle as alu_op
//  br_valid     out  1      one-cycle pulse: branch resolved
//  br_taken     out  1      branch outcome, qualified by br_valid
// BEHAVIOUR
//  Reset: out_valid=0, br_valid=0, br_taken=0, alu_op=ADD, src_a_pc=0, src_b_imm=0, imm_out=0, pc_out=0, illegal=0.
//  in_ready = !out_valid | out_ready (full throughput, one register stage, latency 1 cycle).
//  Capture on in_valid&in_ready&!flush; out_valid cleared when out_ready&out_valid and no new capture.
//  Held fields stable while out_valid&!out_ready.
//  Decode map: R/I-arith -> ADD/SUB/XOR/OR/AND/SLL/SRL/SRA/SLT/SLTU (SUB/SRA only with funct7=0100000);
//   LOAD/STORE/JAL/JALR -> ADD; LUI -> LUI; AUIPC -> AUIPC with src_a_pc=1;
//   BEQ/BNE -> SUB; BLT/BGE -> SLT; BLTU/BGEU -> SLTU; src_b_imm=0 for branches.
//   Branches are not decoded to SUBU.
//  Unknown opcode/funct combination: illegal=1, alu_op=ADD, instruction still flows (no stall).
//  Branch resolution: on handshake (out_valid&out_ready) of a branch, register funct3.
//   Next cycle br_valid=1, br_taken per funct3 computed from alu_zero/alu_lsb sampled at handshake:
//   BEQ=zero, BNE=!zero, BLT/BLTU=lsb, BGE/BGEU=!lsb.
//  Non-branch handshake or no handshake: br_valid=0 next cycle.
//  flush: next cycle out_valid=0, br_valid=0; a same-cycle capture is dropped.
//   Flush wins over in_valid and out_ready; an instruction handshaking in the flush cycle does not produce br_valid.
//  Back-to-back branches: br_valid may pulse on consecutive cycles; no internal queue.
//  reset mid-operation: all state returns to reset values next edge; in-flight instruction discarded.
// CONFIGURATION
//  ALU_ISSUE_STATS_EN defined: adds outputs issued_cnt[CNT_W-1:0] and taken_cnt[CNT_W-1:0], both reset to 0.
//   issued_cnt +1 per out handshake; taken_cnt +1 per br_valid&br_taken.
//   Both wrap modulo 2^CNT_W; flush does not clear them.
//  ALU_ISSUE_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared constants: ALU op codes stay in constants.v.
//  Add opcode (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP) and funct3 branch codes there as well.
//  One sub-module: alu_op_decode (purely combinational instr -> alu_op, selects, imm, illegal, is_branch).
//  The top holds the pipeline register, branch-resolve flop and optional counters.
// TESTING
//  add x1,x2,x3 (0x003100B3), out_ready=1 -> next cycle out_valid=1, alu_op=ADD, src_b_imm=0, illegal=0.
//  beq taken: beq handshake with alu_zero=1 -> next cycle br_valid=1, br_taken=1.
//   bge with alu_lsb=1 -> br_taken=0.
//  Backpressure: out_ready=0 for 3 cycles with new in_valid -> in_ready=0, alu_op/imm_out unchanged; releases with no loss or duplication.
//  auipc x5,0x12345 -> alu_op=AUIPC, src_a_pc=1, src_b_imm=1, imm_out=0x12345000.
//   Opcode 0x7F -> illegal=1.
//  flush asserted during branch handshake plus in_valid -> out_valid=0 and br_valid=0 next cycle.
//  reset asserted mid-stream -> all outputs at reset values next edge.
//  Stats (macro on): 5 issues, 2 taken branches -> issued_cnt=5, taken_cnt=2.
//   CNT_W=4 with 17 issues -> issued_cnt=1.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared constants for the ALU issue stage.
//   - ALU op codes (encoding shared with the execute stage)
//   - RV32I opcodes and branch funct3 codes
//   - decoded-instruction struct, funct3 arithmetic map, branch resolve helper
package alu_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11,
    ALU_SUBU  = 4'd12
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     op;
    logic        a_pc;
    logic        b_imm;
    logic [31:0] imm;
    logic        illegal;
    logic        is_branch;
  } dec_t;

  // funct3 -> op for the shared R/I arithmetic group (funct7 = base form)
  function automatic alu_op_e f3_arith(input logic [2:0] f3);
    alu_op_e r;
    case (f3)
      3'b000:  r = ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // Branch outcome from ALU flags: BEQ/BNE use the SUB zero flag,
  // the others use the SLT/SLTU result bit.
  function automatic logic br_resolve(input logic [2:0] f3, input logic zero,
                                      input logic lsb);
    logic r;
    case (f3)
      F3_BEQ:          r = zero;
      F3_BNE:          r = !zero;
      F3_BLT, F3_BLTU: r = lsb;
      default:         r = !lsb;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: fetch->issue->ALU handshake bundle.
//   slave  : issue-stage view (inputs: in_valid, instr_in, pc_in, flush,
//            out_ready, alu_zero, alu_lsb; everything else driven)
//   master : environment view (mirror of slave)
interface alu_issue_ctrl_if #(parameter int XLEN = 32);
  import alu_issue_ctrl_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  alu_op_e         alu_op;
  logic            src_a_pc;
  logic            src_b_imm;
  logic [XLEN-1:0] imm_out;
  logic [XLEN-1:0] pc_out;
  logic            illegal;
  logic            alu_zero;
  logic            alu_lsb;
  logic            br_valid;
  logic            br_taken;

  modport slave (
    input  in_valid, instr_in, pc_in, flush, out_ready, alu_zero, alu_lsb,
    output in_ready, out_valid, alu_op, src_a_pc, src_b_imm, imm_out, pc_out,
           illegal, br_valid, br_taken
  );

  modport master (
    output in_valid, instr_in, pc_in, flush, out_ready, alu_zero, alu_lsb,
    input  in_ready, out_valid, alu_op, src_a_pc, src_b_imm, imm_out, pc_out,
           illegal, br_valid, br_taken
  );

endinterface

// File: rtl/alu_issue_ctrl_alu_op_decode.sv
// alu_op_decode: combinational RV32I word -> ALU op, operand selects,
// sign-extended immediate, illegal and is_branch flags.
//   instr : raw instruction word
//   dec   : decoded fields (dec_t)
// Undecodable words come out as ADD with all selects/imm cleared and
// illegal set, so they still flow down the pipe.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ill;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec    = '0;
    dec.op = ALU_ADD;
    ill    = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE)                      dec.op = f3_arith(f3);
        else if (f7 == F7_ALT && f3 == 3'b000)  dec.op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)  dec.op = ALU_SRA;
        else                                    ill    = 1'b1;
      end
      OPC_OP_IMM: begin
        // funct7 only matters for the shift forms; elsewhere it is imm bits
        dec.b_imm = 1'b1;
        dec.imm   = imm_i;
        dec.op    = f3_arith(f3);
        if (f3 == 3'b001 && f7 != F7_BASE) ill = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT)       dec.op = ALU_SRA;
          else if (f7 != F7_BASE) ill    = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec.b_imm = 1'b1;
        dec.imm   = imm_i;
        ill       = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.b_imm = 1'b1;
        dec.imm   = imm_s;
        ill       = (f3 > 3'b010);
      end
      OPC_JAL: begin
        dec.a_pc  = 1'b1;
        dec.b_imm = 1'b1;
        dec.imm   = imm_j;
      end
      OPC_JALR: begin
        dec.a_pc  = 1'b1;
        dec.b_imm = 1'b1;
        dec.imm   = imm_i;
        ill       = (f3 != 3'b000);
      end
      OPC_LUI: begin
        dec.op    = ALU_LUI;
        dec.b_imm = 1'b1;
        dec.imm   = imm_u;
      end
      OPC_AUIPC: begin
        dec.op    = ALU_AUIPC;
        dec.a_pc  = 1'b1;
        dec.b_imm = 1'b1;
        dec.imm   = imm_u;
      end
      OPC_BRANCH: begin
        // compare runs rs1 vs rs2, imm_out carries the target offset
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        case (f3)
          F3_BEQ, F3_BNE:   dec.op = ALU_SUB;
          F3_BLT, F3_BGE:   dec.op = ALU_SLT;
          F3_BLTU, F3_BGEU: dec.op = ALU_SLTU;
          default:          ill    = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec         = '0;
      dec.op      = ALU_ADD;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decode-side driver of the integer ALU.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : in_valid/in_ready/instr_in/pc_in/flush from fetch,
//                  out_valid/out_ready/alu_op/src_a_pc/src_b_imm/imm_out/
//                  pc_out/illegal toward the ALU, alu_zero/alu_lsb back,
//                  br_valid/br_taken branch resolution pulse
//   issued_cnt, taken_cnt : statistics, only with ALU_ISSUE_STATS_EN
// One register stage with full throughput; branch outcome resolves one
// cycle after the branch handshakes with the ALU.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  alu_issue_ctrl_if.slave  bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] taken_cnt
`endif
);

  if (XLEN != 32 || CNT_W < 1) begin : g_cfg_chk
    $error("alu_issue_ctrl: XLEN must be 32 and CNT_W must be >= 1");
  end

  dec_t dec;
  alu_op_decode u_dec (.instr(bus.instr_in), .dec(dec));

  logic            vld_q;
  alu_op_e         op_q;
  logic            a_pc_q, b_imm_q, ill_q, is_br_q;
  logic [XLEN-1:0] imm_q, pc_q;
  logic [2:0]      f3_q;
  logic            br_vld_q, br_tkn_q;
  logic            in_rdy, hs, cap, br_hs;

  assign in_rdy = !vld_q || bus.out_ready;
  assign hs     = vld_q && bus.out_ready;
  assign cap    = bus.in_valid && in_rdy && !bus.flush;
  // flush kills the branch even if it handshakes this cycle
  assign br_hs  = hs && is_br_q && !bus.flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q    <= 1'b0;
      op_q     <= ALU_ADD;
      a_pc_q   <= 1'b0;
      b_imm_q  <= 1'b0;
      ill_q    <= 1'b0;
      is_br_q  <= 1'b0;
      imm_q    <= '0;
      pc_q     <= '0;
      f3_q     <= '0;
      br_vld_q <= 1'b0;
      br_tkn_q <= 1'b0;
    end else begin
      br_vld_q <= br_hs;
      br_tkn_q <= br_hs && br_resolve(f3_q, bus.alu_zero, bus.alu_lsb);
      if (bus.flush) begin
        vld_q <= 1'b0;
      end else if (cap) begin
        vld_q   <= 1'b1;
        op_q    <= dec.op;
        a_pc_q  <= dec.a_pc;
        b_imm_q <= dec.b_imm;
        ill_q   <= dec.illegal;
        is_br_q <= dec.is_branch;
        imm_q   <= dec.imm;
        pc_q    <= bus.pc_in;
        f3_q    <= bus.instr_in[14:12];
      end else if (bus.out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q;
  assign bus.alu_op    = op_q;
  assign bus.src_a_pc  = a_pc_q;
  assign bus.src_b_imm = b_imm_q;
  assign bus.imm_out   = imm_q;
  assign bus.pc_out    = pc_q;
  assign bus.illegal   = ill_q;
  assign bus.br_valid  = br_vld_q;
  assign bus.br_taken  = br_tkn_q;

`ifdef ALU_ISSUE_STATS_EN
  // free-running, wrap naturally; flush leaves them alone
  always_ff @(posedge clock) begin
    if (reset) begin
      issued_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      if (hs)                   issued_cnt <= issued_cnt + CNT_W'(1);
      if (br_vld_q && br_tkn_q) taken_cnt  <= taken_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int TB_CNT_W = 4;

  logic clock, reset;
  alu_issue_ctrl_if #(.XLEN(32)) bus ();
`ifdef ALU_ISSUE_STATS_EN
  logic [TB_CNT_W-1:0] issued_cnt, taken_cnt;
`endif

  alu_issue_ctrl #(.XLEN(32), .CNT_W(TB_CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .issued_cnt(issued_cnt),
    .taken_cnt(taken_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic int sext12(input int v);
    return (v >= 2048) ? v - 4096 : v;
  endfunction

  function automatic void model_dec(input logic [31:0] i, output logic [3:0] op,
                                    output bit apc, output bit bimm,
                                    output logic [31:0] imm, output bit ill,
                                    output bit isbr);
    logic [3:0] ar [8];
    int f3, f7, v_i, v_s, v_b, v_j;
    logic [31:0] v_u;
    ar = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    v_i = sext12(int'(i[31:20]));
    v_s = sext12(int'(i[31:25]) * 32 + int'(i[11:7]));
    v_b = (i[7] ? 2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:8]) * 2 - (i[31] ? 4096 : 0);
    v_j = int'(i[19:12]) * 4096 + (i[20] ? 2048 : 0) + int'(i[30:21]) * 2
          - (i[31] ? 1048576 : 0);
    v_u = i & 32'hFFFFF000;
    op = ALU_ADD; apc = 0; bimm = 0; imm = 0; ill = 0; isbr = 0;
    case (i[6:0])
      OPC_OP: begin
        if (f7 == 0) op = ar[f3];
        else if (f7 == 32 && f3 == 0) op = ALU_SUB;
        else if (f7 == 32 && f3 == 5) op = ALU_SRA;
        else ill = 1;
      end
      OPC_OP_IMM: begin
        bimm = 1; imm = 32'(v_i); op = ar[f3];
        if (f3 == 1 && f7 != 0) ill = 1;
        if (f3 == 5 && f7 == 32) op = ALU_SRA;
        else if (f3 == 5 && f7 != 0) ill = 1;
      end
      OPC_LOAD:  begin bimm = 1; imm = 32'(v_i); ill = !(f3 inside {0, 1, 2, 4, 5}); end
      OPC_STORE: begin bimm = 1; imm = 32'(v_s); ill = (f3 > 2); end
      OPC_JAL:   begin apc = 1; bimm = 1; imm = 32'(v_j); end
      OPC_JALR:  begin apc = 1; bimm = 1; imm = 32'(v_i); ill = (f3 != 0); end
      OPC_LUI:   begin op = ALU_LUI; bimm = 1; imm = v_u; end
      OPC_AUIPC: begin op = ALU_AUIPC; apc = 1; bimm = 1; imm = v_u; end
      OPC_BRANCH: begin
        isbr = 1; imm = 32'(v_b);
        if (f3 == 0 || f3 == 1) op = ALU_SUB;
        else if (f3 == 4 || f3 == 5) op = ALU_SLT;
        else if (f3 == 6 || f3 == 7) op = ALU_SLTU;
        else ill = 1;
      end
      default: ill = 1;
    endcase
    if (ill) begin op = ALU_ADD; apc = 0; bimm = 0; imm = 0; isbr = 0; end
  endfunction

  function automatic bit model_taken(input logic [2:0] f3, input bit z, input bit l);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4, 3'd6: return l;
      default: return !l;
    endcase
  endfunction

  bit                  started = 0, m_rst = 0;
  bit                  m_valid = 0, m_brv = 0, m_brt = 0;
  logic [31:0]         m_instr = 0, m_pc = 0;
  logic [TB_CNT_W-1:0] m_iss = 0, m_tk = 0;

  always @(posedge clock) begin
    logic [3:0] op; bit apc, bimm, ill, isbr, hs, nb; logic [31:0] imm;
    if (reset) begin
      m_valid = 0; m_brv = 0; m_brt = 0; m_iss = 0; m_tk = 0;
      m_rst = 1; started = 1;
    end else begin
      model_dec(m_instr, op, apc, bimm, imm, ill, isbr);
      hs = m_valid && bus.out_ready;
      if (m_brv && m_brt) m_tk = m_tk + 1'b1;
      if (hs) m_iss = m_iss + 1'b1;
      nb = hs && isbr && !bus.flush;
      m_brt = nb && model_taken(m_instr[14:12], bus.alu_zero, bus.alu_lsb);
      m_brv = nb;
      if (bus.flush) m_valid = 0;
      else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
        m_valid = 1; m_instr = bus.instr_in; m_pc = bus.pc_in;
      end else if (bus.out_ready) m_valid = 0;
      m_rst = 0;
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clock) begin
    logic [3:0] op; bit apc, bimm, ill, isbr; logic [31:0] imm;
    if (started) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("br_valid", 32'(bus.br_valid), 32'(m_brv));
      if (m_brv) chk("br_taken", 32'(bus.br_taken), 32'(m_brt));
      if (m_rst) begin
        chk("rst_br_taken", 32'(bus.br_taken), 0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
        chk("rst_src_a_pc", 32'(bus.src_a_pc), 0);
        chk("rst_src_b_imm", 32'(bus.src_b_imm), 0);
        chk("rst_imm_out", bus.imm_out, 0);
        chk("rst_pc_out", bus.pc_out, 0);
        chk("rst_illegal", 32'(bus.illegal), 0);
      end else if (m_valid) begin
        model_dec(m_instr, op, apc, bimm, imm, ill, isbr);
        chk("alu_op", 32'(bus.alu_op), 32'(op));
        chk("src_a_pc", 32'(bus.src_a_pc), 32'(apc));
        chk("src_b_imm", 32'(bus.src_b_imm), 32'(bimm));
        chk("imm_out", bus.imm_out, imm);
        chk("pc_out", bus.pc_out, m_pc);
        chk("illegal", 32'(bus.illegal), 32'(ill));
      end
`ifdef ALU_ISSUE_STATS_EN
      chk("issued_cnt", 32'(issued_cnt), 32'(m_iss));
      chk("taken_cnt", 32'(taken_cnt), 32'(m_tk));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy);
    bus.in_valid = v; bus.instr_in = ins; bus.pc_in = pc; bus.out_ready = ordy;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [9];
    logic [31:0] r;
    int k;
    opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
             OPC_STORE, OPC_OP_IMM, OPC_OP};
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) r[6:0] = opcs[k];
    if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    bus.flush = 0; bus.alu_zero = 0; bus.alu_lsb = 0;
    step(); step();
    reset = 1'b0;

    // add x1,x2,x3
    drive(1, 32'h003100B3, 32'h100, 1);
    step();
    chk("add_out_valid", 32'(bus.out_valid), 1);
    chk("add_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
    chk("add_src_b_imm", 32'(bus.src_b_imm), 0);
    chk("add_illegal", 32'(bus.illegal), 0);
    chk("add_pc_out", bus.pc_out, 32'h100);

    // auipc x5,0x12345
    drive(1, 32'h12345297, 32'h104, 1);
    step();
    chk("auipc_alu_op", 32'(bus.alu_op), 32'(ALU_AUIPC));
    chk("auipc_src_a_pc", 32'(bus.src_a_pc), 1);
    chk("auipc_src_b_imm", 32'(bus.src_b_imm), 1);
    chk("auipc_imm_out", bus.imm_out, 32'h12345000);

    // unknown opcode
    drive(1, 32'h0000007F, 32'h108, 1);
    step();
    chk("ill_out_valid", 32'(bus.out_valid), 1);
    chk("ill_illegal", 32'(bus.illegal), 1);
    chk("ill_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));

    // beq taken
    drive(1, 32'h00000063, 32'h10C, 1);
    step();
    chk("beq_alu_op", 32'(bus.alu_op), 32'(ALU_SUB));
    drive(0, 0, 0, 1);
    bus.alu_zero = 1;
    step();
    chk("beq_br_valid", 32'(bus.br_valid), 1);
    chk("beq_br_taken", 32'(bus.br_taken), 1);

    // bge with lsb=1 -> not taken
    drive(1, 32'h00005063, 32'h110, 1);
    step();
    drive(0, 0, 0, 1);
    bus.alu_zero = 0; bus.alu_lsb = 1;
    step();
    chk("bge_br_valid", 32'(bus.br_valid), 1);
    chk("bge_br_taken", 32'(bus.br_taken), 0);

    // backpressure: addi x1,x0,-5 held while sub x1,x2,x3 waits
    drive(1, 32'hFFB00093, 32'h200, 0);
    step();
    drive(1, 32'h403100B3, 32'h204, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
      chk("bp_imm_out", bus.imm_out, 32'hFFFFFFFB);
    end
    bus.out_ready = 1;
    step();
    chk("bp_next_op", 32'(bus.alu_op), 32'(ALU_SUB));
    chk("bp_next_pc", bus.pc_out, 32'h204);
    drive(0, 0, 0, 1);
    step();
    chk("bp_drained", 32'(bus.out_valid), 0);

    // flush during branch handshake with new input
    drive(1, 32'h00000063, 32'h300, 0);
    step();
    drive(1, 32'h003100B3, 32'h304, 1);
    bus.flush = 1; bus.alu_zero = 1;
    step();
    bus.flush = 0;
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_br_valid", 32'(bus.br_valid), 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom_range(0, 9) < 6);
      bus.flush    = ($urandom_range(0, 19) == 0);
      bus.alu_zero = $urandom_range(0, 1) == 1;
      bus.alu_lsb  = $urandom_range(0, 1) == 1;
      reset        = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 0; bus.flush = 0;

    // reset mid-stream
    drive(1, 32'h12345297, 32'h44, 0);
    step();
    chk("mid_out_valid", 32'(bus.out_valid), 1);
    reset = 1;
    step();
    reset = 0;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_op", 32'(bus.alu_op), 32'(ALU_ADD));
    chk("rst_imm", bus.imm_out, 0);
    chk("rst_pc", bus.pc_out, 0);
    chk("rst_src_a", 32'(bus.src_a_pc), 0);

`ifdef ALU_ISSUE_STATS_EN
    // 5 issues, 2 taken branches
    begin
      logic [31:0] seq [5];
      seq = '{32'h00000063, 32'h003100B3, 32'h00000063, 32'h003100B3, 32'h003100B3};
      bus.alu_zero = 1;
      for (int k = 0; k < 5; k++) begin
        drive(1, seq[k], 32'(k * 4), 1);
        step();
      end
      drive(0, 0, 0, 1);
      step(); step();
      chk("stats_issued", 32'(issued_cnt), 5);
      chk("stats_taken", 32'(taken_cnt), 2);
    end
    reset = 1;
    step();
    reset = 0;
    for (int k = 0; k < 17; k++) begin
      drive(1, 32'h003100B3, 32'(k * 4), 1);
      step();
    end
    drive(0, 0, 0, 1);
    step(); step();
    chk("stats_wrap", 32'(issued_cnt), 1);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
